// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU operation codes, forwarding selects and
// the EX-stage control bundle used when a bubble is inserted.
package mips_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_AND  = 5'b00001,
    ALU_XOR  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_NOR  = 5'b00100,
    ALU_SUB  = 5'b00101,
    ALU_ANDI = 5'b00110,
    ALU_XORI = 5'b00111,
    ALU_ORI  = 5'b01000,
    ALU_JR   = 5'b01001,
    ALU_BEQ  = 5'b01010,
    ALU_BNE  = 5'b01011,
    ALU_BGEZ = 5'b01100,
    ALU_BGTZ = 5'b01101,
    ALU_BLEZ = 5'b01110,
    ALU_BLTZ = 5'b01111,
    ALU_SLL  = 5'b10000,
    ALU_SRL  = 5'b10001,
    ALU_SRA  = 5'b10010,
    ALU_SLT  = 5'b10011,
    ALU_SLTU = 5'b10100
  } alu_code_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/forward_unit.sv
// Combinational hazard logic for the ID/EX stage: operand forward selects for
// the instruction in EX and the load-use stall against the instruction in ID.
module forward_unit
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          i_mem_reg_write,
  input  logic [RW-1:0] i_mem_write_reg,
  input  logic          i_wb_reg_write,
  input  logic [RW-1:0] i_wb_write_reg,
  input  logic [RW-1:0] i_ex_rs,
  input  logic [RW-1:0] i_ex_rt,
  input  logic          i_ex_valid,
  input  logic          i_ex_mem_read,
  input  logic [RW-1:0] i_ex_write_reg,
  input  logic          i_id_valid,
  input  logic          i_id_use_rs,
  input  logic          i_id_use_rt,
  input  logic [RW-1:0] i_id_rs,
  input  logic [RW-1:0] i_id_rt,
  output fwd_sel_e      o_sel_rs,
  output fwd_sel_e      o_sel_rt,
  output logic          o_stall
);

  // EX/MEM is checked first so the younger result wins; $0 never forwards.
  function automatic fwd_sel_e select_for(input logic [RW-1:0] src);
    if (i_mem_reg_write && (i_mem_write_reg != '0) && (i_mem_write_reg == src))
      return FWD_MEM;
    else if (i_wb_reg_write && (i_wb_write_reg != '0) && (i_wb_write_reg == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  logic w_rs_hit;
  logic w_rt_hit;

  assign o_sel_rs = select_for(i_ex_rs);
  assign o_sel_rt = select_for(i_ex_rt);

  assign w_rs_hit = i_id_use_rs && (i_id_rs == i_ex_write_reg);
  assign w_rt_hit = i_id_use_rt && (i_id_rt == i_ex_write_reg);
  assign o_stall  = i_ex_valid && i_ex_mem_read && (i_ex_write_reg != '0) &&
                    (w_rs_hit || w_rt_hit) && i_id_valid;

endmodule

// File: rtl/id_ex_forward.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB operand
// forwarding, load-use stall detection, branch flush and global hold.
module id_ex_forward
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [4:0]    id_ALUCode,
  input  logic [DW-1:0] id_RsData,
  input  logic [DW-1:0] id_RtData,
  input  logic [DW-1:0] id_Imm,
  input  logic [4:0]    id_Shamt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_UseRs,
  input  logic          id_UseRt,
  input  logic          id_ALUSrcA,
  input  logic          id_ALUSrcB,
  input  logic          id_RegDst,
  input  logic          id_RegWrite,
  input  logic          id_MemRead,
  input  logic          id_MemWrite,
  input  logic          id_MemtoReg,
  input  logic          mem_RegWrite,
  input  logic [RW-1:0] mem_WriteReg,
  input  logic [DW-1:0] mem_Result,
  input  logic          wb_RegWrite,
  input  logic [RW-1:0] wb_WriteReg,
  input  logic [DW-1:0] wb_WriteData,
  output logic          stall,
  output logic [4:0]    ALUCode,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] ex_StoreData,
  output logic [RW-1:0] ex_WriteReg,
  output logic          ex_valid,
  output logic          ex_RegWrite,
  output logic          ex_MemRead,
  output logic          ex_MemWrite,
  output logic          ex_MemtoReg
);

  ex_ctrl_t      r_ctrl;
  alu_code_e     r_alu_code;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm;
  logic [4:0]    r_shamt;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_write_reg;
  logic          r_alu_src_a;
  logic          r_alu_src_b;

  fwd_sel_e      w_sel_rs;
  fwd_sel_e      w_sel_rt;
  logic          w_stall;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;

  // A bubble is the same all-zero image as reset, so one branch covers both;
  // a held stage ignores flush and stall, which keeps stall asserted.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset || (!hold && (flush || w_stall))) begin
      r_ctrl      <= BUBBLE_CTRL;
      r_alu_code  <= ALU_ADD;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_alu_src_a <= 1'b0;
      r_alu_src_b <= 1'b0;
    end else if (!hold) begin
      r_ctrl      <= '{valid: id_valid, reg_write: id_RegWrite, mem_read: id_MemRead,
                       mem_write: id_MemWrite, mem_to_reg: id_MemtoReg};
      r_alu_code  <= alu_code_e'(id_ALUCode);
      r_rs_data   <= id_RsData;
      r_rt_data   <= id_RtData;
      r_imm       <= id_Imm;
      r_shamt     <= id_Shamt;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_write_reg <= id_RegDst ? id_rd : id_rt;
      r_alu_src_a <= id_ALUSrcA;
      r_alu_src_b <= id_ALUSrcB;
    end
  end

  forward_unit #(.RW(RW)) u_forward_unit (
    .i_mem_reg_write (mem_RegWrite),
    .i_mem_write_reg (mem_WriteReg),
    .i_wb_reg_write  (wb_RegWrite),
    .i_wb_write_reg  (wb_WriteReg),
    .i_ex_rs         (r_rs),
    .i_ex_rt         (r_rt),
    .i_ex_valid      (r_ctrl.valid),
    .i_ex_mem_read   (r_ctrl.mem_read),
    .i_ex_write_reg  (r_write_reg),
    .i_id_valid      (id_valid),
    .i_id_use_rs     (id_UseRs),
    .i_id_use_rt     (id_UseRt),
    .i_id_rs         (id_rs),
    .i_id_rt         (id_rt),
    .o_sel_rs        (w_sel_rs),
    .o_sel_rt        (w_sel_rt),
    .o_stall         (w_stall)
  );

  always_comb begin
    w_fwd_rs = r_rs_data;
    w_fwd_rt = r_rt_data;
    case (w_sel_rs)
      FWD_MEM: w_fwd_rs = mem_Result;
      FWD_WB:  w_fwd_rs = wb_WriteData;
      default: w_fwd_rs = r_rs_data;
    endcase
    case (w_sel_rt)
      FWD_MEM: w_fwd_rt = mem_Result;
      FWD_WB:  w_fwd_rt = wb_WriteData;
      default: w_fwd_rt = r_rt_data;
    endcase
  end

  assign stall        = w_stall;
  assign ALUCode      = r_alu_code;
  assign A            = r_alu_src_a ? {{(DW-5){1'b0}}, r_shamt} : w_fwd_rs;
  assign B            = r_alu_src_b ? r_imm : w_fwd_rt;
  assign ex_StoreData = w_fwd_rt;
  assign ex_WriteReg  = r_write_reg;
  assign ex_valid     = r_ctrl.valid;
  assign ex_RegWrite  = r_ctrl.reg_write;
  assign ex_MemRead   = r_ctrl.mem_read;
  assign ex_MemWrite  = r_ctrl.mem_write;
  assign ex_MemtoReg  = r_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_forward.sv
// Self-checking bench for id_ex_forward: directed pipeline scenarios followed by
// randomized traffic, all compared against an instruction-level reference model.
module tb_id_ex_forward;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, hold, flush, id_valid;
  logic [4:0]  id_ALUCode, id_Shamt;
  logic [31:0] id_RsData, id_RtData, id_Imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_UseRs, id_UseRt, id_ALUSrcA, id_ALUSrcB, id_RegDst;
  logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg;
  logic        mem_RegWrite, wb_RegWrite;
  logic [4:0]  mem_WriteReg, wb_WriteReg;
  logic [31:0] mem_Result, wb_WriteData;
  logic        stall;
  logic [4:0]  ALUCode;
  logic [31:0] A, B, ex_StoreData;
  logic [4:0]  ex_WriteReg;
  logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_forward #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_ALUCode(id_ALUCode), .id_RsData(id_RsData), .id_RtData(id_RtData),
    .id_Imm(id_Imm), .id_Shamt(id_Shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_UseRs(id_UseRs), .id_UseRt(id_UseRt), .id_ALUSrcA(id_ALUSrcA),
    .id_ALUSrcB(id_ALUSrcB), .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
    .mem_RegWrite(mem_RegWrite), .mem_WriteReg(mem_WriteReg), .mem_Result(mem_Result),
    .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_WriteData(wb_WriteData),
    .stall(stall), .ALUCode(ALUCode), .A(A), .B(B), .ex_StoreData(ex_StoreData),
    .ex_WriteReg(ex_WriteReg), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg)
  );

  // Reference model: the instruction currently occupying EX (all zero = bubble).
  typedef struct packed {
    logic        valid;
    logic [4:0]  alu;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt, rs, rt, wr;
    logic        src_a, src_b, rw, mr, mw, m2r;
  } ex_t;

  ex_t ex_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regval);
    if (mem_RegWrite && mem_WriteReg != 0 && mem_WriteReg == idx) return mem_Result;
    if (wb_RegWrite && wb_WriteReg != 0 && wb_WriteReg == idx) return wb_WriteData;
    return regval;
  endfunction

  function automatic logic model_stall();
    logic hit;
    hit = (id_UseRs && id_rs == ex_m.wr) || (id_UseRt && id_rt == ex_m.wr);
    return ex_m.valid && ex_m.mr && ex_m.wr != 0 && hit && id_valid;
  endfunction

  task automatic compare_all();
    logic [31:0] exp_a, exp_b;
    exp_a = ex_m.src_a ? {27'b0, ex_m.shamt} : fwd(ex_m.rs, ex_m.rs_data);
    exp_b = ex_m.src_b ? ex_m.imm : fwd(ex_m.rt, ex_m.rt_data);
    check("stall", 32'(stall), 32'(model_stall()));
    check("alucode", 32'(ALUCode), 32'(ex_m.alu));
    check("A", A, exp_a);
    check("B", B, exp_b);
    check("store_data", ex_StoreData, fwd(ex_m.rt, ex_m.rt_data));
    check("write_reg", 32'(ex_WriteReg), 32'(ex_m.wr));
    check("ctrl", 32'({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg}),
          32'({ex_m.valid, ex_m.rw, ex_m.mr, ex_m.mw, ex_m.m2r}));
  endtask

  task automatic model_update();
    if (reset) ex_m = '0;
    else if (hold) ex_m = ex_m;
    else if (flush || model_stall()) ex_m = '0;
    else ex_m = '{valid: id_valid, alu: id_ALUCode, rs_data: id_RsData, rt_data: id_RtData,
                  imm: id_Imm, shamt: id_Shamt, rs: id_rs, rt: id_rt,
                  wr: id_RegDst ? id_rd : id_rt, src_a: id_ALUSrcA, src_b: id_ALUSrcB,
                  rw: id_RegWrite, mr: id_MemRead, mw: id_MemWrite, m2r: id_MemtoReg};
  endtask

  // Compare at the falling edge, then advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    hold = 0; flush = 0; id_valid = 0; id_ALUCode = 0; id_Shamt = 0;
    id_RsData = 0; id_RtData = 0; id_Imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_UseRs = 0; id_UseRt = 0; id_ALUSrcA = 0; id_ALUSrcB = 0; id_RegDst = 0;
    id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_MemtoReg = 0;
    mem_RegWrite = 0; mem_WriteReg = 0; mem_Result = 0;
    wb_RegWrite = 0; wb_WriteReg = 0; wb_WriteData = 0;
  endtask

  task automatic id_instr(input logic [4:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic regdst, input logic mr);
    id_valid = 1; id_ALUCode = alu; id_rs = rs; id_rt = rt; id_rd = rd;
    id_RsData = rsd; id_RtData = rtd; id_UseRs = 1; id_UseRt = !mr; id_RegDst = regdst;
    id_RegWrite = 1; id_MemRead = mr; id_MemtoReg = mr; id_ALUSrcB = mr;
    id_ALUSrcA = 0; id_Shamt = 0; id_Imm = mr ? 32'h10 : 32'h0; id_MemWrite = 0;
  endtask

  task automatic load_lw5();
    id_instr(ALU_ADD, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    id_instr(ALU_ADD, 5'd5, 5'd1, 5'd6, 32'h0, 32'h3, 1'b1, 1'b0);
    #1;
  endtask

  task automatic randomize_inputs();
    reset = ($urandom_range(0, 99) < 3);
    hold = ($urandom_range(0, 99) < 12);
    flush = ($urandom_range(0, 99) < 10);
    id_valid = ($urandom_range(0, 99) < 85);
    id_ALUCode = 5'($urandom_range(0, 20));
    id_RsData = $urandom; id_RtData = $urandom; id_Imm = $urandom;
    id_Shamt = 5'($urandom_range(0, 31));
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_UseRs = 1'($urandom_range(0, 1)); id_UseRt = 1'($urandom_range(0, 1));
    id_ALUSrcA = ($urandom_range(0, 99) < 20); id_ALUSrcB = 1'($urandom_range(0, 1));
    id_RegDst = 1'($urandom_range(0, 1)); id_RegWrite = 1'($urandom_range(0, 1));
    id_MemRead = ($urandom_range(0, 99) < 40); id_MemWrite = 1'($urandom_range(0, 1));
    id_MemtoReg = 1'($urandom_range(0, 1));
    mem_RegWrite = 1'($urandom_range(0, 1)); mem_WriteReg = 5'($urandom_range(0, 3));
    mem_Result = $urandom;
    wb_RegWrite = 1'($urandom_range(0, 1)); wb_WriteReg = 5'($urandom_range(0, 3));
    wb_WriteData = $urandom;
  endtask

  initial begin
    set_idle();
    reset = 1;
    @(posedge clk);
    #1;
    ex_m = '0;
    step();
    reset = 0;
    step();
    step();
    check("reset_ctrl", 32'({ex_valid, ex_RegWrite, ex_MemRead, stall}), 32'h0);
    check("reset_alucode", 32'(ALUCode), 32'(ALU_ADD));

    // add $3,$1,$2 then sub $4,$3,$1 with both EX/MEM and MEM/WB producing $3.
    id_instr(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b1, 1'b0);
    step();
    id_instr(ALU_SUB, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 1'b1, 1'b0);
    step();
    set_idle();
    mem_RegWrite = 1; mem_WriteReg = 5'd3; mem_Result = 32'd12;
    wb_RegWrite = 1; wb_WriteReg = 5'd3; wb_WriteData = 32'd99;
    #1;
    check("mem_priority_A", A, 32'd12);
    check("sub_alucode", 32'(ALUCode), 32'(ALU_SUB));
    step();

    // Load-use: one stall cycle, then a bubble, then the dependent add.
    set_idle();
    load_lw5();
    check("lu_stall", 32'(stall), 32'd1);
    step();
    check("lu_bubble", 32'({ex_valid, ex_RegWrite, ex_MemRead, stall}), 32'h0);
    step();
    check("lu_loaded", 32'({ex_valid, stall, 3'b000, ex_WriteReg}), 32'h206);

    // Load-use under hold: frozen, stall stays up, bubble only after release.
    set_idle();
    load_lw5();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", 32'({stall, ex_valid, ex_MemRead, ex_WriteReg}), 32'hE5);
      step();
    end
    hold = 0;
    step();
    check("hold_bubble", 32'({ex_valid, stall}), 32'h0);
    step();

    // sll $2,$1,4 with EX/MEM claiming to write $0.
    set_idle();
    id_valid = 1; id_ALUCode = ALU_SLL; id_ALUSrcA = 1; id_Shamt = 5'd4;
    id_rt = 5'd1; id_rd = 5'd2; id_RtData = 32'h1; id_UseRt = 1; id_RegDst = 1; id_RegWrite = 1;
    step();
    set_idle();
    mem_RegWrite = 1; mem_WriteReg = 5'd0; mem_Result = 32'hFFFF;
    #1;
    check("sll_A", A, 32'd4);
    check("sll_B", B, 32'h1);
    step();

    // Flush coinciding with a load-use stall: one bubble, then the next instruction.
    set_idle();
    load_lw5();
    flush = 1;
    step();
    check("flush_bubble", 32'({ex_valid, ex_RegWrite}), 32'h0);
    flush = 0;
    id_instr(ALU_OR, 5'd7, 5'd1, 5'd8, 32'h3, 32'h4, 1'b1, 1'b0);
    step();
    check("flush_next", 32'({ex_valid, ex_WriteReg}), 32'h28);

    // Reset while a load-use stall is pending.
    set_idle();
    load_lw5();
    reset = 1;
    step();
    reset = 0;
    #1;
    check("reset_mid_stall", 32'(stall), 32'h0);
    step();

    for (int i = 0; i < 800; i++) begin
      randomize_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_forward.md
Name: id_ex_forward

Overview:
- ID/EX pipeline stage of the 32-bit MIPS core; sits directly upstream of the ALU.
- Registers decoded operands and control from ID.
- Drives the ALU's ALUCode, A and B, with EX/MEM and MEM/WB operand forwarding applied.
- Detects load-use hazards, stalls IF/ID and inserts a bubble; supports branch flush and global hold.

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  global freeze (memory not ready); stage keeps its contents.
- flush  in  1  branch/jump taken; kill the instruction entering EX.
- id_valid  in  1  ID holds a real instruction.
- id_ALUCode  in  5  ALU operation from decoder.
- id_RsData, id_RtData  in  DW  register file read data.
- id_Imm  in  DW  sign- or zero-extended immediate.
- id_Shamt  in  5  shift amount field.
- id_rs, id_rt, id_rd  in  RW  register indices.
- id_UseRs, id_UseRt  in  1  instruction reads rs / rt.
- id_ALUSrcA  in  1  1 selects {27'b0,Shamt} for A.
- id_ALUSrcB  in  1  1 selects Imm for B.
- id_RegDst  in  1  1 selects rd as destination, 0 selects rt.
- id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg  in  1  control.
- mem_RegWrite  in  1  EX/MEM writes a register.
- mem_WriteReg  in  RW  EX/MEM destination.
- mem_Result  in  DW  EX/MEM ALU result.
- wb_RegWrite  in  1  MEM/WB writes a register.
- wb_WriteReg  in  RW  MEM/WB destination.
- wb_WriteData  in  DW  MEM/WB write-back data.
- stall  out  1  load-use hazard; IF/ID must hold.
- ALUCode  out  5  to ALU.
- A, B  out  DW  to ALU.
- ex_StoreData  out  DW  forwarded rt value for stores.
- ex_WriteReg  out  RW  destination index.
- ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg  out  1  control to EX/MEM.

Behaviour:
- Register update on each clk edge, first match wins:
  1. reset: clear all state.
  2. hold: keep all state.
  3. flush or stall: load a bubble (valid and all control bits 0, ALUCode=5'b00000, data 0).
  4. Otherwise: load the ID inputs.
- Reset values: every output 0, including stall (no valid load in EX) and ALUCode=00000 (add).
- ex_WriteReg is latched as id_RegDst ? id_rd : id_rt.
- A bubble never writes, never forwards and never triggers a hazard.
- Forwarding is combinational on registered rs/rt indices; zero added latency.
- For each source s in {rs, rt}:
  1. If mem_RegWrite and mem_WriteReg!=0 and mem_WriteReg==s: use mem_Result (EX/MEM has priority).
  2. Else if wb_RegWrite and wb_WriteReg!=0 and wb_WriteReg==s: use wb_WriteData.
  3. Else use the registered read data.
- Register 0 is never forwarded.
- A = ALUSrcA ? {27'b0,Shamt} : fwdRs.
- B = ALUSrcB ? Imm : fwdRt.
- ex_StoreData = fwdRt, always.
- Load-use stall is combinational:
  - stall = ex_valid & ex_MemRead & ex_WriteReg!=0 & ((id_UseRs & id_rs==ex_WriteReg) | (id_UseRt & id_rt==ex_WriteReg)) & id_valid.
  - stall asserts for exactly one cycle per hazard; the bubble then clears it.
- Boundary cases:
  - hold with stall: state frozen; stall stays asserted; no bubble inserted.
  - flush with stall: flush bubble only; no double bubble.
  - reset mid-stall: stall 0 in the next cycle.
- Write-back-to-ID same-cycle bypass is the register file's responsibility, not this block's.

Decomposition:
- Shared package mips_pkg:
  - ALUCode encodings: add 00000, and 00001, xor 00010, or 00011, nor 00100, sub 00101, andi 00110, xori 00111, ori 01000, jr 01001, beq..bltz 01010–01111, sll 10000, srl 10001, sra 10010, slt 10011, sltu 10100.
  - Forward select encodings: FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - Bubble control constant.
- One sub-module, forward_unit (combinational):
  - Computes the 2-bit selects for rs and rt plus the stall term.
  - id_ex_forward holds the registers and the muxes.

Test Plan:
1. Reset then 2 idle cycles -> all outputs 0, ALUCode=00000, stall=0.
2. add $3,$1,$2 (RsData=5, RtData=7) followed by sub $4,$3,$1 with mem_RegWrite=1, mem_WriteReg=3, mem_Result=12; wb_WriteReg=3, wb_WriteData=99 -> A=12 (EX/MEM wins over WB), ALUCode=00101.
3. lw $5 in EX (ex_MemRead=1, ex_WriteReg=5), ID add reads rs=5 -> stall=1 for one cycle, next cycle ex_valid=0 and all control 0, then the add loads with stall=0.
4. Same as 3 but hold=1 for 3 cycles -> contents unchanged, stall held at 1, no bubble until hold drops.
5. sll $2,$1,4 (ALUSrcA=1, Shamt=4, RtData=0x1) with mem_WriteReg=0, mem_RegWrite=1, mem_Result=0xFFFF -> A=4, B=0x1; no forwarding from $0.
6. flush=1 and stall=1 in the same cycle -> single bubble; following cycle loads the next ID instruction; ex_RegWrite=0 during the bubble.
